wishbone_arbiter: RTL and testbench



---
 rtl/wishbone_pkg.sv | 13 +
 rtl/wishbone_arbiter_if.sv | 49 ++++
 rtl/wishbone_rr_picker.sv | 27 ++
 rtl/wishbone_arbiter.sv | 143 ++++++++++++++
 tb/tb_wishbone_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: arbiter state encoding and default bus widths.
// No ports; imported by the arbiter, its interface and future interconnect blocks.
package wishbone_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 4;
  localparam int unsigned WB_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

endpackage

// File: rtl/wishbone_arbiter_if.sv
// Bundle of all bus signals around the Wishbone arbiter.
//   m_*   : packed per-master request side (master i at [i*W +: W])
//   s_*   : single shared slave side
//   gnt   : one-hot current grant (debug)
// Modports: master (bus masters), slave (shared peripheral), arbiter (the arbiter).
interface wishbone_arbiter_if #(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned ADDR_WIDTH = wishbone_pkg::WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = wishbone_pkg::WB_DATA_WIDTH
);

  logic [N_MASTERS-1:0]            m_cyc;
  logic [N_MASTERS-1:0]            m_stb;
  logic [N_MASTERS-1:0]            m_we;
  logic [N_MASTERS*ADDR_WIDTH-1:0] m_adr;
  logic [N_MASTERS*DATA_WIDTH-1:0] m_dat_w;
  logic [N_MASTERS-1:0]            m_ack;
  logic [N_MASTERS-1:0]            m_err;
  logic [DATA_WIDTH-1:0]           m_dat_r;

  logic                  s_cyc;
  logic                  s_stb;
  logic                  s_we;
  logic [ADDR_WIDTH-1:0] s_adr;
  logic [DATA_WIDTH-1:0] s_dat_w;
  logic                  s_ack;
  logic [DATA_WIDTH-1:0] s_dat_r;

  logic [N_MASTERS-1:0] gnt;

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w,
    input  m_ack, m_err, m_dat_r, gnt
  );

  modport slave (
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w,
    output s_ack, s_dat_r
  );

  modport arbiter (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w,
    output m_ack, m_err, m_dat_r,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w,
    input  s_ack, s_dat_r,
    output gnt
  );

endinterface

// File: rtl/wishbone_rr_picker.sv
// Combinational round-robin priority encoder.
//   req   in  N           request vector
//   ptr   in  PTR_WIDTH   index with highest priority this round
//   pick  out N           one-hot: first requester at or after ptr, wrapping
//   valid out 1           any request present
module wishbone_rr_picker #(
  parameter int unsigned N         = 2,
  parameter int unsigned PTR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [N-1:0]         pick,
  output logic                 valid
);

  logic [N-1:0] rot_req;
  logic [N-1:0] rot_pick;

  always_comb begin
    // Rotate so that ptr lands on bit 0, isolate the lowest set bit, rotate back.
    rot_req  = N'({req, req} >> ptr);
    rot_pick = rot_req & (~rot_req + N'(1));
    pick     = N'(({rot_pick, rot_pick} << ptr) >> N);
    valid    = |req;
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic slave between N_MASTERS
// masters. A grant is held for a whole cyc burst; a watchdog turns a strobe the
// slave never acknowledges into a one-cycle error pulse.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  wishbone_arbiter_if.arbiter: master side m_*, slave side s_*, debug gnt
module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic clk,
  input logic rst,
  wishbone_arbiter_if.arbiter bus
);

  localparam int unsigned PtrW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(N_MASTERS - 1);

  arb_state_e           state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [PtrW-1:0]      gidx_q, gidx_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [WdW-1:0]       wd_q, wd_d;

  logic [N_MASTERS-1:0] pick;
  logic                 pick_valid;
  logic [PtrW-1:0]      pick_idx;

  logic                  sel_cyc, sel_stb, sel_we;
  logic [ADDR_WIDTH-1:0] sel_adr;
  logic [DATA_WIDTH-1:0] sel_dat_w;
  logic                  busy, timeout, stb_out;

  wishbone_rr_picker #(
    .N         (N_MASTERS),
    .PTR_WIDTH (PtrW)
  ) u_picker (
    .req   (bus.m_cyc),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (pick[i]) pick_idx = PtrW'(i);
    end
  end

  // Signals of the currently granted master.
  always_comb begin
    sel_cyc   = 1'b0;
    sel_stb   = 1'b0;
    sel_we    = 1'b0;
    sel_adr   = '0;
    sel_dat_w = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (gidx_q == PtrW'(i)) begin
        sel_cyc   = bus.m_cyc[i];
        sel_stb   = bus.m_stb[i];
        sel_we    = bus.m_we[i];
        sel_adr   = bus.m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_dat_w = bus.m_dat_w[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy = (state_q == StBusy);
  // Uses the raw strobe, so the forced-low s_stb cannot feed back into this term.
  // An ack on the last watchdog cycle wins over the timeout.
  assign timeout = busy && sel_stb && !bus.s_ack && (wd_q == WdLast);
  assign stb_out = busy && sel_stb && !timeout;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StBusy;
          gnt_d   = pick;
          gidx_d  = pick_idx;
        end
      end
      StBusy: begin
        if (!sel_cyc) begin
          state_d = StIdle;
          gnt_d   = '0;
          ptr_d   = (gidx_q == PtrLast) ? '0 : gidx_q + PtrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Counts only while a strobe is waiting; any ack, idle strobe or timeout clears it.
    if (busy && sel_stb && !bus.s_ack && !timeout) begin
      wd_d = wd_q + WdW'(1);
    end else begin
      wd_d = '0;
    end
  end

  // Outputs.
  always_comb begin
    bus.s_cyc   = busy && sel_cyc;
    bus.s_stb   = stb_out;
    bus.s_we    = busy && sel_we;
    bus.s_adr   = busy ? sel_adr : '0;
    bus.s_dat_w = busy ? sel_dat_w : '0;
    bus.m_ack   = (bus.s_ack && stb_out) ? gnt_q : '0;
    bus.m_err   = timeout ? gnt_q : '0;
    bus.m_dat_r = busy ? bus.s_dat_r : '0;
    bus.gnt     = gnt_q;
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: directed scenarios followed by random bursts.
// Stimulus pushes expected grants and responses (with the cycle they are due)
// into queues; negedge monitors pop and compare whenever the DUT shows a grant
// or an ack/err pulse.
module tb_wishbone_arbiter;
  import wishbone_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = WB_ADDR_WIDTH;
  localparam int unsigned DW = WB_DATA_WIDTH;
  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wishbone_arbiter_if #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wishbone_arbiter #(
    .N_MASTERS  (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic          chk_dat;
    logic [DW-1:0] dat;
    int            cycle;
  } rsp_t;

  typedef struct {
    logic [N-1:0] gnt;
    int           cycle;
  } gnt_t;

  rsp_t rsp_q[$];
  gnt_t gnt_q[$];
  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  logic [N-1:0] req;   // what the bench drives on m_cyc
  int           mp;    // reference round-robin pointer
  int           cur;   // reference granted master, -1 when idle

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_winner(logic [N-1:0] r, int p);
    int idx;
    for (int off = 0; off < N; off++) begin
      idx = (p + off) % N;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic void push_gnt(int m, int at);
    gnt_t g;
    g.gnt   = onehot(m);
    g.cycle = at;
    gnt_q.push_back(g);
  endfunction

  // Response monitor.
  always @(negedge clk) begin : rsp_mon
    rsp_t e;
    if (!rst && ((bus.m_ack | bus.m_err) != '0)) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", 32'({bus.m_ack, bus.m_err}), 32'd0);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_cycle", cyc_cnt, e.cycle);
        check("m_ack", 32'(bus.m_ack), 32'(e.ack));
        check("m_err", 32'(bus.m_err), 32'(e.err));
        if (e.chk_dat) check("m_dat_r", 32'(bus.m_dat_r), 32'(e.dat));
        if (e.err != '0) check("s_stb_at_err", 32'(bus.s_stb), 32'd0);
      end
    end
  end

  // Grant monitor.
  logic [N-1:0] prev_gnt = '0;
  always @(negedge clk) begin : gnt_mon
    gnt_t g;
    if (!rst && bus.gnt != prev_gnt && bus.gnt != '0) begin
      if (gnt_q.size() == 0) begin
        check("unexpected_gnt", 32'(bus.gnt), 32'd0);
      end else begin
        g = gnt_q.pop_front();
        check("gnt", 32'(bus.gnt), 32'(g.gnt));
        check("gnt_cycle", cyc_cnt, g.cycle);
      end
    end
    prev_gnt = bus.gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From idle: raise requests, expect a grant on the next edge.
  task automatic acquire(logic [N-1:0] mask);
    req        = mask;
    bus.m_cyc  = req;
    cur        = rr_winner(req, mp);
    push_gnt(cur, cyc_cnt + 1);
    tick();
  endtask

  // One strobe by master g; the slave acks lat cycles after stb rises (never if lat >= TO).
  task automatic transfer(int g, logic we, logic [AW-1:0] adr, logic [DW-1:0] wdat,
                          int lat, logic [DW-1:0] rdat);
    rsp_t e;
    int   stop;
    bit   acked;
    acked = (lat <= TO - 1);
    stop  = acked ? lat : TO - 1;
    bus.m_stb[g]              = 1'b1;
    bus.m_we[g]               = we;
    bus.m_adr[g*AW +: AW]     = adr;
    bus.m_dat_w[g*DW +: DW]   = wdat;
    e.ack     = acked ? onehot(g) : '0;
    e.err     = acked ? '0 : onehot(g);
    e.chk_dat = acked && !we;
    e.dat     = rdat;
    e.cycle   = cyc_cnt + stop;
    rsp_q.push_back(e);
    for (int k = 0; k <= stop; k++) begin
      bus.s_ack   = (k == lat);
      bus.s_dat_r = (k == lat) ? rdat : DW'($urandom);
      if (k == 0) begin
        @(negedge clk);
        check("s_cyc", 32'(bus.s_cyc), 32'd1);
        check("s_stb", 32'(bus.s_stb), 32'd1);
        check("s_adr", 32'(bus.s_adr), 32'(adr));
        check("s_we", 32'(bus.s_we), 32'(we));
        if (we) check("s_dat_w", 32'(bus.s_dat_w), 32'(wdat));
        @(posedge clk);
        #1;
      end else begin
        tick();
      end
    end
    bus.m_stb[g] = 1'b0;
    bus.s_ack    = 1'b0;
  endtask

  // Granted master g drops cyc; next_req is the request set seen in the idle cycle.
  task automatic release_bus(int g, logic [N-1:0] next_req);
    req       = next_req;
    req[g]    = 1'b0;
    bus.m_cyc = req;
    mp        = (g + 1) % N;
    tick();
    // Stray ack while idle must be ignored.
    bus.s_ack   = 1'($urandom_range(0, 1));
    bus.s_dat_r = DW'($urandom);
    req         = next_req;
    bus.m_cyc   = req;
    @(negedge clk);
    check("idle_gnt", 32'(bus.gnt), 32'd0);
    check("idle_s_cyc", 32'(bus.s_cyc), 32'd0);
    check("idle_m_dat_r", 32'(bus.m_dat_r), 32'd0);
    if (req != '0) begin
      cur = rr_winner(req, mp);
      push_gnt(cur, cyc_cnt + 1);
    end else begin
      cur = -1;
    end
    @(posedge clk);
    #1;
    bus.s_ack = 1'b0;
  endtask

  initial begin
    int nx, r, lat;
    logic [N-1:0] nr;
    bus.m_cyc   = '0;
    bus.m_stb   = '0;
    bus.m_we    = '0;
    bus.m_adr   = '0;
    bus.m_dat_w = '0;
    bus.s_ack   = 1'b0;
    bus.s_dat_r = 8'hFF;
    req = '0;
    mp  = 0;
    cur = -1;

    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_s_cyc", 32'(bus.s_cyc), 32'd0);
    check("rst_s_stb", 32'(bus.s_stb), 32'd0);
    check("rst_s_adr", 32'(bus.s_adr), 32'd0);
    check("rst_m_ack", 32'(bus.m_ack), 32'd0);
    check("rst_m_err", 32'(bus.m_err), 32'd0);
    check("rst_m_dat_r", 32'(bus.m_dat_r), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Simultaneous request after reset: master 0 wins, writes 0xA5 to 0x3.
    acquire(2'b11);
    transfer(0, 1'b1, 4'h3, 8'hA5, 1, 8'h00);
    // Master 1 takes over after one idle cycle and reads 0x3C from 0x7.
    release_bus(0, 2'b10);
    transfer(1, 1'b0, 4'h7, 8'h00, 0, 8'h3C);
    // Both keep requesting: grants alternate.
    release_bus(1, 2'b11);
    transfer(0, 1'b1, 4'h1, 8'h12, 0, 8'h00);
    transfer(0, 1'b0, 4'h2, 8'h00, 0, 8'h34);
    release_bus(0, 2'b11);
    transfer(1, 1'b0, 4'h4, 8'h00, 2, 8'h56);
    release_bus(1, 2'b11);
    // Watchdog: no ack, then a normal strobe, then ack on the last allowed cycle.
    transfer(0, 1'b0, 4'h5, 8'h00, TO + 5, 8'h00);
    transfer(0, 1'b0, 4'h6, 8'h00, 2, 8'h5A);
    transfer(0, 1'b1, 4'h2, 8'h11, TO - 1, 8'h00);
    release_bus(0, 2'b11);

    // Reset in the middle of master 1's pending strobe.
    bus.m_stb[1] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    bus.m_stb = '0;
    req       = '1;
    bus.m_cyc = req;
    mp        = 0;
    @(negedge clk);
    check("mid_rst_s_cyc", 32'(bus.s_cyc), 32'd0);
    check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    check("mid_rst_m_ack", 32'(bus.m_ack), 32'd0);
    check("mid_rst_m_err", 32'(bus.m_err), 32'd0);
    cur = rr_winner(req, mp);
    push_gnt(cur, cyc_cnt + 1);
    @(posedge clk);
    #1;

    // Random bursts.
    for (int b = 0; b < 40; b++) begin
      if (cur < 0) acquire(N'($urandom_range(1, (1 << N) - 1)));
      nx = $urandom_range(1, 3);
      for (int j = 0; j < nx; j++) begin
        r   = $urandom_range(0, 9);
        lat = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TO - 1 : (r == 8) ? TO - 2 : TO + 3;
        transfer(cur, 1'($urandom), AW'($urandom), DW'($urandom), lat, DW'($urandom));
      end
      nr = N'($urandom);
      release_bus(cur, nr);
    end

    repeat (3) tick();
    check("rsp_queue_empty", rsp_q.size(), 32'd0);
    check("gnt_queue_empty", gnt_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
